pipe_field: RTL and testbench
=============================

# pipe_field

Generates and scrolls the obstacle pipes for the flappy-bird playfield and renders them per pixel. Sits directly upstream of the bird block: its `pipe_on` feeds the bird's collision detector. It consumes the bird's `refresh` frame strobe, `flight` and `collision`. It also produces the score, counting one point per pipe cleared.

## Interface
Parameters:
- `NUM_PIPES`, 3: pipe slots on the track.
- `PIPE_W`, 52: pipe width, px.
- `SPACING`, 220: right-edge distance between consecutive pipes, px.
- `GAP_H`, 120: vertical opening, px.
- `GAP_MIN`, 40: minimum gap top row.
- `CAP_H`, 8: cap rows on each side of the gap.
- `SPEED`, 2: px moved per frame.
- `SCREEN_W`, 640: visible width.
- `GROUND_Y`, 440: first ground row; pipes are never drawn at or below it.
- `BIRD_X`, 300: bird left column, used as the scoring line.

Ports:
- `clk` in 1: pixel clock.
- `reset_n` in 1: reset, synchronous and active-low.
- `x` in 11: current scan column.
- `y` in 10: current scan row.
- `refresh` in 1: one-cycle frame strobe from the bird.
- `flight` in 1: high while the bird is in PLAY.
- `collision` in 1: sticky collision flag from the bird.
- `pipe_on` out 1: current pixel belongs to a pipe.
- `pipe_rgb` out 12: pipe colour; 12'h000 when not on a pipe.
- `score` out 8: pipes cleared, saturating.
- `score_tick` out 1: one-cycle pulse per point.
- `scrolling` out 1: high in SCROLL.

## Operation
- FSM states:
  - IDLE (reset state): pipes parked, no motion.
  - SCROLL: pipes move.
  - FROZEN: pipes hold position until reset.
- FSM transitions, evaluated only on cycles with `refresh`=1:
  - IDLE→SCROLL when `flight`=1.
  - SCROLL→FROZEN when `collision`=1 or `flight`=0.
  - FROZEN has no exit except reset.
- Per slot i, a registered right edge `px[i]` (11 bit, exclusive) and gap top `gt[i]` (10 bit).
  - Column span is [px-PIPE_W, px).
- Reset values:
  - `px[i]` = SCREEN_W+PIPE_W+i·SPACING, i.e. 692, 912, 1132.
  - `gt[i]` = GAP_MIN+64·(i+1), i.e. 104, 168, 232.
- Motion, on a `refresh` cycle in SCROLL whose transition stays in SCROLL:
  - Each `px[i]` -= SPEED.
  - If `px[i]` ≤ SPEED, the slot retires instead: `px[i]` += NUM_PIPES·SPACING−SPEED, and `gt[i]` = GAP_MIN + lfsr[7:0].
  - The maximum gap bottom is 40+255+120 = 415 < GROUND_Y.
- No motion occurs on the refresh that transitions SCROLL→FROZEN or IDLE→SCROLL.
- LFSR: 16-bit Galois, mask 16'hB400, reset seed 16'hACE1.
  - Advances once per `refresh` in every state.
  - When several slots retire on the same frame, they all use the pre-advance value.
- Scoring: on a motion frame, a slot whose old `px` > BIRD_X and new `px` ≤ BIRD_X scores.
  - `score` increments, saturating at 255.
  - `score_tick`=1 for that one cycle.
  - At most one slot can cross per frame, because SPACING > SPEED.
- Pixel logic is purely combinational from `x`, `y` and the registers. It has zero latency, so it is cycle-aligned with the bird's `bird_on`.
  - `pipe_on` = some slot satisfies x in span, y < GROUND_Y, and (y < gt or y ≥ gt+GAP_H).
- Colour for a pipe pixel:
  - 12'h060 on the two outermost columns of the span.
  - 12'h0c0 within CAP_H rows of the gap edge.
  - 12'h0a0 otherwise.
  - Precedence is edge > cap > body.
- Pipes are drawn in every state, including FROZEN.

## Timing
- All registers update on `posedge clk`.
- `reset_n`=0 takes effect at the next edge. Reset mid-frame or mid-scroll returns to all reset values on that edge.
- Reset values of outputs: `score`=0, `score_tick`=0, `scrolling`=0. `pipe_on`/`pipe_rgb` follow the reset positions; nothing is visible until scrolling starts.
- State, `px`, `gt`, `score` and `lfsr` change only on the edge that samples `refresh`=1.
  - Exception: `score_tick` clears on the next edge.
- `flight` and `collision` are sampled only with `refresh`. Values between strobes are ignored.
- Width rules:
  - Span test uses x+PIPE_W ≥ px (12-bit compare), never px−PIPE_W, so there is no underflow.
  - gt+GAP_H is computed at 11 bits.

## Structure
- Shared package `flappy_pkg`:
  - FSM enum `pipe_state_t` {IDLE, SCROLL, FROZEN}.
  - Screen constants SCREEN_W and GROUND_Y.
  - BIRD_X.
  - Colour constants.
- One sub-module `lfsr16` (ports `clk`, `reset_n`, `en`, `q[15:0]`).
- Slots are a generate loop inside `pipe_field`.

## Test plan
- Reset, then 5 refreshes with `flight`=0 → state IDLE; `px` stays 692/912/1132; lfsr stepped 5 times from 16'hACE1.
- Refresh with `flight`=1, then 10 refreshes → `px[0]`=672; `scrolling`=1.
- Scroll until `px[0]` crosses 300 → exactly one `score_tick` pulse; `score`=1.
- Scroll until `px[0]` ≤ 2 → on the next motion frame `px[0]` = old+658; `gt[0]` = 40 + lfsr[7:0]; `gt[0]` + 120 ≤ 415.
- Raise `collision` with `refresh` → FROZEN on that edge; `px` unchanged for 20 further frames.
- Pixel checks with `px[0]`=400, `gt[0]`=104:
  - (349,50) → on, 12'h060.
  - (370,100) → on, 12'h0c0.
  - (370,150) → off.
  - (370,300) → on, 12'h0a0.
  - (370,445) → off.
- Reset asserted mid-scroll → all reset values are restored on that edge.

Source files
------------

// File: rtl/flappy_pkg.sv
// Shared flappy-bird playfield definitions: pipe FSM encoding, screen geometry,
// scoring line, pipe colours and LFSR constants.
package flappy_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCROLL,
    FROZEN
  } pipe_state_t;

  localparam int SCREEN_W = 640;
  localparam int GROUND_Y = 440;
  localparam int BIRD_X   = 300;

  localparam logic [11:0] PIPE_EDGE_RGB = 12'h060;
  localparam logic [11:0] PIPE_CAP_RGB  = 12'h0c0;
  localparam logic [11:0] PIPE_BODY_RGB = 12'h0a0;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_MASK = 16'hB400;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR; steps once per enabled cycle, used to pick pipe gap heights.
module lfsr16 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  output logic [15:0] q
);
  import flappy_pkg::*;

  logic [15:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (en) q_d = {1'b0, q_q[15:1]} ^ (q_q[0] ? LFSR_MASK : '0);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) q_q <= LFSR_SEED;
    else          q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/pipe_field.sv
// Obstacle pipe track: scrolls NUM_PIPES slots on each frame strobe, recycles them
// with random gaps, scores crossings of the bird column and renders pipe pixels.
module pipe_field #(
  parameter int NUM_PIPES = 3,
  parameter int PIPE_W    = 52,
  parameter int SPACING   = 220,
  parameter int GAP_H     = 120,
  parameter int GAP_MIN   = 40,
  parameter int CAP_H     = 8,
  parameter int SPEED     = 2,
  parameter int SCREEN_W  = flappy_pkg::SCREEN_W,
  parameter int GROUND_Y  = flappy_pkg::GROUND_Y,
  parameter int BIRD_X    = flappy_pkg::BIRD_X
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [10:0] x,
  input  logic [9:0]  y,
  input  logic        refresh,
  input  logic        flight,
  input  logic        collision,
  output logic        pipe_on,
  output logic [11:0] pipe_rgb,
  output logic [7:0]  score,
  output logic        score_tick,
  output logic        scrolling
);
  import flappy_pkg::*;

  localparam logic [10:0] SPEED_W    = 11'(SPEED);
  localparam logic [10:0] RETIRE_ADD = 11'(NUM_PIPES * SPACING - SPEED);
  localparam logic [10:0] BIRD_X_W   = 11'(BIRD_X);
  localparam logic [9:0]  GAP_MIN_W  = 10'(GAP_MIN);
  localparam logic [11:0] PIPE_W_W   = 12'(PIPE_W);
  localparam logic [10:0] GAP_H_W    = 11'(GAP_H);
  localparam logic [10:0] CAP_H_W    = 11'(CAP_H);
  localparam logic [9:0]  GROUND_W   = 10'(GROUND_Y);

  pipe_state_t state_q, state_d;
  logic        motion;
  logic [15:0] lfsr;
  logic [7:0]  score_q, score_d;
  logic        score_tick_q, score_tick_d;

  logic [NUM_PIPES-1:0] on_vec;
  logic [NUM_PIPES-1:0] cross_vec;
  logic [11:0]          rgb_all [NUM_PIPES];
  logic [10:0]          px_all  [NUM_PIPES];
  logic [9:0]           gt_all  [NUM_PIPES];

  lfsr16 u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (refresh),
    .q       (lfsr)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (refresh) begin
      case (state_q)
        IDLE:    if (flight) state_d = SCROLL;
        SCROLL:  if (collision || !flight) state_d = FROZEN;
        default: state_d = state_q;
      endcase
    end
  end

  // Motion only on frames that begin and end in SCROLL; the entry and exit frames hold still.
  always_comb begin
    scrolling = (state_q == SCROLL);
    motion    = refresh && (state_q == SCROLL) && (state_d == SCROLL);
  end

  for (genvar i = 0; i < NUM_PIPES; i++) begin : g_slot
    localparam logic [10:0] PX_RST = 11'(SCREEN_W + PIPE_W + i * SPACING);
    localparam logic [9:0]  GT_RST = 10'(GAP_MIN + 64 * (i + 1));

    logic [10:0] px_q, px_d;
    logic [9:0]  gt_q, gt_d;
    logic        cross_s, on_s, in_span, edge_col, cap_row, solid;
    logic [11:0] x12, px12;
    logic [10:0] y11, gt11, gap_bot;
    logic [11:0] rgb_s;

    always_comb begin
      px_d = px_q;
      gt_d = gt_q;
      if (motion) begin
        if (px_q <= SPEED_W) begin
          px_d = px_q + RETIRE_ADD;
          gt_d = GAP_MIN_W + {2'b00, lfsr[7:0]};
        end else begin
          px_d = px_q - SPEED_W;
        end
      end
      cross_s = motion && (px_q > BIRD_X_W) && (px_d <= BIRD_X_W);
    end

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        px_q <= PX_RST;
        gt_q <= GT_RST;
      end else begin
        px_q <= px_d;
        gt_q <= gt_d;
      end
    end

    // Span test adds PIPE_W to x rather than subtracting from px, so no underflow near column 0.
    always_comb begin
      x12      = {1'b0, x};
      px12     = {1'b0, px_q};
      y11      = {1'b0, y};
      gt11     = {1'b0, gt_q};
      gap_bot  = gt11 + GAP_H_W;
      in_span  = (x12 < px12) && (x12 + PIPE_W_W >= px12);
      edge_col = (x12 + 12'd2 >= px12) || (x12 + PIPE_W_W < px12 + 12'd2);
      solid    = (y11 < gt11) || (y11 >= gap_bot);
      cap_row  = ((y11 < gt11) && (y11 + CAP_H_W >= gt11)) ||
                 ((y11 >= gap_bot) && (y11 < gap_bot + CAP_H_W));
      on_s     = in_span && (y < GROUND_W) && solid;
      rgb_s    = '0;
      if (on_s) begin
        if (edge_col)     rgb_s = PIPE_EDGE_RGB;
        else if (cap_row) rgb_s = PIPE_CAP_RGB;
        else              rgb_s = PIPE_BODY_RGB;
      end
    end

    assign on_vec[i]    = on_s;
    assign cross_vec[i] = cross_s;
    assign rgb_all[i]   = rgb_s;
    assign px_all[i]    = px_q;
    assign gt_all[i]    = gt_q;
  end

  always_comb begin
    score_d      = score_q;
    score_tick_d = 1'b0;
    if (|cross_vec) begin
      score_tick_d = 1'b1;
      if (score_q != 8'hFF) score_d = score_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      score_q      <= '0;
      score_tick_q <= 1'b0;
    end else begin
      score_q      <= score_d;
      score_tick_q <= score_tick_d;
    end
  end

  always_comb begin
    logic hit;
    hit      = 1'b0;
    pipe_rgb = '0;
    for (int unsigned k = 0; k < NUM_PIPES; k++) begin
      if (on_vec[k] && !hit) begin
        pipe_rgb = rgb_all[k];
        hit      = 1'b1;
      end
    end
    pipe_on = |on_vec;
  end

  assign score      = score_q;
  assign score_tick = score_tick_q;

endmodule

// File: tb/tb_pipe_field.sv
// Self-checking bench for pipe_field: directed frame sequence with randomized
// between-strobe noise and pixel probes, checked against a behavioural track model.
module tb_pipe_field;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [10:0] x;
  logic [9:0]  y;
  logic        refresh, flight, collision;
  logic        pipe_on;
  logic [11:0] pipe_rgb;
  logic [7:0]  score;
  logic        score_tick, scrolling;

  pipe_field dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .x          (x),
    .y          (y),
    .refresh    (refresh),
    .flight     (flight),
    .collision  (collision),
    .pipe_on    (pipe_on),
    .pipe_rgb   (pipe_rgb),
    .score      (score),
    .score_tick (score_tick),
    .scrolling  (scrolling)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Behavioural model: 0 = parked, 1 = moving, 2 = frozen
  int m_mode;
  int m_px [3];
  int m_gt [3];
  int m_score;
  int m_tick;
  int m_lfsr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int lfsr_next(input int v);
    int r;
    r = v >> 1;
    if (v % 2 == 1) r = r ^ 'hB400;
    return r;
  endfunction

  task automatic model_reset();
    m_mode  = 0;
    m_score = 0;
    m_tick  = 0;
    m_lfsr  = 'hACE1;
    for (int i = 0; i < 3; i++) begin
      m_px[i] = 640 + 52 + i * 220;
      m_gt[i] = 40 + 64 * (i + 1);
    end
  endtask

  task automatic model_step(input logic fl, input logic col);
    int old;
    m_tick = 0;
    if (m_mode == 0) begin
      if (fl) m_mode = 1;
    end else if (m_mode == 1) begin
      if (col || !fl) m_mode = 2;
      else begin
        for (int i = 0; i < 3; i++) begin
          old = m_px[i];
          if (old <= 2) begin
            m_px[i] = old + 3 * 220 - 2;
            m_gt[i] = 40 + (m_lfsr % 256);
          end else begin
            m_px[i] = old - 2;
          end
          if (old > 300 && m_px[i] <= 300) begin
            m_tick = 1;
            if (m_score < 255) m_score++;
          end
        end
      end
    end
    m_lfsr = lfsr_next(m_lfsr);
  endtask

  // Returns {on, rgb} for a pixel from the model's pipe geometry.
  function automatic logic [12:0] pix_model(input int xx, input int yy);
    int lo, g;
    for (int i = 0; i < 3; i++) begin
      lo = m_px[i] - 52;
      g  = m_gt[i];
      if (xx >= lo && xx < m_px[i] && yy < 440 && (yy < g || yy >= g + 120)) begin
        if (xx < lo + 2 || xx >= m_px[i] - 2) return {1'b1, 12'h060};
        if ((yy < g && yy >= g - 8) || (yy >= g + 120 && yy < g + 128)) return {1'b1, 12'h0c0};
        return {1'b1, 12'h0a0};
      end
    end
    return {1'b0, 12'h000};
  endfunction

  task automatic check_regs();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("px%0d", i), 32'(dut.px_all[i]), 32'(m_px[i]));
      check($sformatf("gt%0d", i), 32'(dut.gt_all[i]), 32'(m_gt[i]));
    end
    check("lfsr", 32'(dut.lfsr), 32'(m_lfsr));
  endtask

  task automatic probe(input int xx, input int yy);
    logic [12:0] e;
    x = 11'(xx);
    y = 10'(yy);
    #1;
    e = pix_model(xx, yy);
    check($sformatf("pipe_on(%0d,%0d)", xx, yy), 32'(pipe_on), 32'(e[12]));
    check($sformatf("pipe_rgb(%0d,%0d)", xx, yy), 32'(pipe_rgb), 32'(e[11:0]));
  endtask

  task automatic frame(input logic fl, input logic col);
    @(negedge clk);
    refresh   = 1'b1;
    flight    = fl;
    collision = col;
    @(posedge clk);
    model_step(fl, col);
    #1;
    refresh = 1'b0;
    check("score_tick", 32'(score_tick), 32'(m_tick));
    check("score", 32'(score), 32'(m_score));
    check("scrolling", 32'(scrolling), 32'(m_mode == 1));
    check_regs();
    repeat ($urandom_range(1, 3)) begin
      @(negedge clk);
      flight    = 1'($urandom);
      collision = 1'($urandom);
      probe($urandom_range(0, 1200), $urandom_range(0, 479));
    end
    check("score_tick_clear", 32'(score_tick), 32'd0);
  endtask

  initial begin
    int ticks;
    int old_px;
    int old_lfsr;
    reset_n = 1'b0; refresh = 1'b0; flight = 1'b0; collision = 1'b0; x = '0; y = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_score", 32'(score), 32'd0);
    check("rst_tick", 32'(score_tick), 32'd0);
    check("rst_scrolling", 32'(scrolling), 32'd0);
    check_regs();
    probe($urandom_range(0, 639), $urandom_range(0, 479));
    @(negedge clk);
    reset_n = 1'b1;

    repeat (5) frame(1'b0, 1'b0);
    check("lfsr_after5", 32'(dut.lfsr), 32'(lfsr_next(lfsr_next(lfsr_next(lfsr_next(lfsr_next('hACE1)))))));

    frame(1'b1, 1'b0);
    repeat (10) frame(1'b1, 1'b0);
    check("px0_after10", 32'(dut.px_all[0]), 32'd672);
    check("scrolling_on", 32'(scrolling), 32'd1);

    ticks = 0;
    for (int n = 0; n < 400 && m_px[0] > 300; n++) begin
      frame(1'b1, 1'b0);
      if (score_tick === 1'b0 && m_tick == 1) ticks = ticks;
      if (m_tick == 1) ticks++;
      if (m_px[0] == 400) begin
        @(negedge clk);
        probe(349, 50);
        check("dir_349_50_rgb", 32'(pipe_rgb), 32'h060);
        probe(370, 100);
        check("dir_370_100_rgb", 32'(pipe_rgb), 32'h0c0);
        probe(370, 150);
        check("dir_370_150_on", 32'(pipe_on), 32'd0);
        probe(370, 300);
        check("dir_370_300_rgb", 32'(pipe_rgb), 32'h0a0);
        probe(370, 445);
        check("dir_370_445_on", 32'(pipe_on), 32'd0);
      end
    end
    check("first_cross_px0", 32'(dut.px_all[0]), 32'd300);
    check("first_score", 32'(score), 32'd1);

    for (int n = 0; n < 400 && m_px[0] > 2; n++) frame(1'b1, 1'b0);
    old_px   = m_px[0];
    old_lfsr = m_lfsr;
    frame(1'b1, 1'b0);
    check("retire_px0", 32'(dut.px_all[0]), 32'(old_px + 658));
    check("retire_gt0", 32'(dut.gt_all[0]), 32'(40 + (old_lfsr % 256)));
    check("retire_gt0_max", 32'(32'(dut.gt_all[0]) + 120 <= 415), 32'd1);

    frame(1'b1, 1'b1);
    check("frozen_scrolling", 32'(scrolling), 32'd0);
    repeat (20) frame(1'($urandom), 1'($urandom));
    check("frozen_px0", 32'(dut.px_all[0]), 32'(old_px + 658));

    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    @(negedge clk);
    reset_n = 1'b1;
    frame(1'b1, 1'b0);
    repeat (7) frame(1'b1, 1'b0);
    @(negedge clk);
    reset_n = 1'b0; refresh = 1'b1; flight = 1'b1; collision = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    refresh = 1'b0;
    check("midrst_scrolling", 32'(scrolling), 32'd0);
    check("midrst_score", 32'(score), 32'd0);
    check("midrst_tick", 32'(score_tick), 32'd0);
    check("midrst_px0", 32'(dut.px_all[0]), 32'd692);
    check_regs();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) frame(1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
